// File: rtl/sync_filter_multi.sv
// Multi-channel boundary conditioner: flop-chain synchroniser, debounce filter, registered edge pulses.
// Latency STAGES+FILTER_CYCLES edges; no backpressure, sample_en only pauses the filter.
module sync_filter_multi #(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter int               FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int             CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_nxt;
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  assign sync_out = sync_q[STAGES-1];
  assign filt_out = filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A channel's count only runs while its synchronised level disagrees with filt_out.
  always_comb begin
    filt_nxt = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (sync_out[i] == filt_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (sample_en) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_nxt[i] = sync_out[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q     <= filt_nxt;
      rise_pulse <= ~filt_q & filt_nxt;
      fall_pulse <= filt_q & ~filt_nxt;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: two configurations driven from shared inputs, checked against a delay-line/run-length model.
module tb_sync_filter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [3:0] async_in;
  logic [3:0] a_sync, a_filt, a_rise, a_fall;
  logic [3:0] b_sync, b_filt, b_rise, b_fall;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: input history, filtered level, run length and pulses per configuration.
  logic [3:0] hist[$];
  logic [3:0] m_filt [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  int         m_run  [2][4];

  always #5 clk = ~clk;

  sync_filter_multi #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'b0000), .FILTER_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .async_in(async_in), .sample_en(sample_en),
    .sync_out(a_sync), .filt_out(a_filt), .rise_pulse(a_rise), .fall_pulse(a_fall)
  );

  sync_filter_multi #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0000), .FILTER_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .async_in(async_in), .sample_en(sample_en),
    .sync_out(b_sync), .filt_out(b_filt), .rise_pulse(b_rise), .fall_pulse(b_fall)
  );

  function automatic int stages_of(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int fc_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic [3:0] m_sync(int k);
    return hist[hist.size() - stages_of(k)];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back(4'b0000);
    for (int k = 0; k < 2; k++) begin
      m_filt[k] = 4'b0000;
      m_rise[k] = 4'b0000;
      m_fall[k] = 4'b0000;
      for (int i = 0; i < 4; i++) m_run[k][i] = 0;
    end
  endtask

  // Advance model and DUTs by one clock edge, then compare every output of both instances.
  task automatic step();
    logic [3:0] s;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        s = m_sync(k);
        m_rise[k] = 4'b0000;
        m_fall[k] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
          if (s[i] == m_filt[k][i]) begin
            m_run[k][i] = 0;
          end else if (sample_en) begin
            m_run[k][i] = m_run[k][i] + 1;
            if (m_run[k][i] == fc_of(k)) begin
              m_filt[k][i] = s[i];
              m_run[k][i]  = 0;
              if (s[i]) m_rise[k][i] = 1'b1;
              else      m_fall[k][i] = 1'b1;
            end
          end
        end
      end
      hist.push_back(async_in);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
    chk("a_sync", a_sync, m_sync(0));
    chk("a_filt", a_filt, m_filt[0]);
    chk("a_rise", a_rise, m_rise[0]);
    chk("a_fall", a_fall, m_fall[0]);
    chk("b_sync", b_sync, m_sync(1));
    chk("b_filt", b_filt, m_filt[1]);
    chk("b_rise", b_rise, m_rise[1]);
    chk("b_fall", b_fall, m_fall[1]);
  endtask

  initial begin
    int ea, eb;
    logic [3:0] flip;
    model_reset();
    rst       = 1'b1;
    sample_en = 1'b1;
    async_in  = 4'hF;

    // Reset holds everything at zero despite all-ones inputs.
    repeat (3) begin
      step();
      chk("rst_filt", a_filt, 4'h0);
      chk("rst_pulse", a_rise | a_fall, 4'h0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_pulse", a_rise | a_fall | b_rise | b_fall, 4'h0);
    repeat (8) step();
    chk("all_high_a", a_filt, 4'hF);
    async_in = 4'h0;
    repeat (8) step();
    chk("all_low_a", a_filt, 4'h0);

    // Clean rising then falling edge on bit 0: latency 5 (config a) and 4 (config b).
    async_in[0] = 1'b1;
    ea = 0; eb = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (a_rise[0] && ea == 0) ea = e;
      if (b_rise[0] && eb == 0) eb = e;
    end
    chk("rise_lat_a", 4'(ea), 4'd5);
    chk("rise_lat_b", 4'(eb), 4'd4);
    async_in[0] = 1'b0;
    ea = 0; eb = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (a_fall[0] && ea == 0) ea = e;
      if (b_fall[0] && eb == 0) eb = e;
    end
    chk("fall_lat_a", 4'(ea), 4'd5);
    chk("fall_lat_b", 4'(eb), 4'd4);

    // Two-cycle glitch on bit 1 is rejected by the 3-cycle filter.
    async_in[1] = 1'b1;
    repeat (2) step();
    async_in[1] = 1'b0;
    ea = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      ea = ea | int'(a_filt[1] | a_rise[1] | a_fall[1]);
    end
    chk("glitch_a", 4'(ea), 4'd0);

    // sample_en low freezes the filter on bit 2.
    sample_en   = 1'b0;
    async_in[2] = 1'b1;
    repeat (12) step();
    chk("gated_filt2", {3'b000, a_filt[2]}, 4'd0);
    sample_en = 1'b1;
    repeat (2) step();
    chk("en_two_edges", {3'b000, a_filt[2]}, 4'd0);
    step();
    chk("en_three_edges", {3'b000, a_filt[2]}, 4'd1);

    // Reset after two counts on bit 3 discards the partial count.
    async_in[3] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_rst_filt", a_filt, 4'h0);
    rst = 1'b0;
    ea = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (a_rise[3] && ea == 0) ea = e;
    end
    chk("mid_rst_lat", 4'(ea), 4'd5);

    // Bits 0 and 3 toggle together while bit 1 glitches.
    async_in[0] = ~async_in[0];
    async_in[3] = ~async_in[3];
    async_in[1] = 1'b1;
    step();
    async_in[1] = 1'b0;
    repeat (8) step();
    chk("parallel_filt", a_filt, 4'b0101);

    // Random phase with slow toggles, gated sample_en and occasional reset.
    for (int n = 0; n < 400; n++) begin
      flip      = 4'($urandom) & 4'($urandom) & 4'($urandom);
      async_in  = async_in ^ flip;
      sample_en = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
